// File: rtl/branch_pred_unit.sv
// Branch prediction unit: a direct-mapped BTB with saturating direction counters
// supplies the IF-stage next-PC guess. Jumps, branches and JPR/JRL are resolved
// in ID, which produces a flush code and a corrected redirect PC and trains the BTB.
// Saturating counters track resolved and mispredicted control-flow instructions.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   pc_IF / pred_pc    fetch PC in, predicted next fetch PC out (combinational)
//   valid_ID, stall_ID ID holds a real instruction / ID is frozen this cycle
//   pc_ID, pc_1_ID     PC of the ID instruction and that PC + 1
//   pc_after_ID        PC actually fetched after the ID instruction
//   is_jtype/is_branch/is_jr, branch_cond   instruction class and branch outcome
//   jmp_target/br_target/jr_target          resolved targets
//   flush_code, redirect_pc                 resolution result (combinational)
//   branch_cnt, mispred_cnt                 saturating perf counters
module branch_pred_unit #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned CTR_W     = 2,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned PRED_MODE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] pc_IF,
   output logic [WORD_SIZE-1:0] pred_pc,
   input  logic                 valid_ID,
   input  logic                 stall_ID,
   input  logic [WORD_SIZE-1:0] pc_ID,
   input  logic [WORD_SIZE-1:0] pc_1_ID,
   input  logic [WORD_SIZE-1:0] pc_after_ID,
   input  logic                 is_jtype,
   input  logic                 is_branch,
   input  logic                 is_jr,
   input  logic                 branch_cond,
   input  logic [WORD_SIZE-1:0] jmp_target,
   input  logic [WORD_SIZE-1:0] br_target,
   input  logic [WORD_SIZE-1:0] jr_target,
   output logic [2:0]           flush_code,
   output logic [WORD_SIZE-1:0] redirect_pc,
   output logic [CNT_W-1:0]     branch_cnt,
   output logic [CNT_W-1:0]     mispred_cnt
);

   localparam int unsigned DEPTH = 2 ** IDX_W;
   localparam int unsigned TAG_W = WORD_SIZE - IDX_W;

   localparam logic [CTR_W-1:0] CTR_MAX    = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(2 ** (CTR_W - 1));
   localparam logic [CTR_W-1:0] CTR_INIT   = CTR_W'((2 ** (CTR_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   localparam logic [2:0] NICE_PRED = 3'd0;
   localparam logic [2:0] JMP_FLUSH = 3'd1;
   localparam logic [2:0] BR_FLUSH  = 3'd2;
   localparam logic [2:0] NBR_FLUSH = 3'd3;
   localparam logic [2:0] JR_FLUSH  = 3'd4;

   typedef struct packed {
      logic                 valid;
      logic                 jump;
      logic [TAG_W-1:0]     tag;
      logic [WORD_SIZE-1:0] target;
      logic [CTR_W-1:0]     ctr;
   } btb_entry_t;

   btb_entry_t btb [DEPTH];

   logic [IDX_W-1:0]     if_idx, id_idx;
   logic [TAG_W-1:0]     if_tag, id_tag;
   logic                 if_hit, id_hit;
   logic                 train_en;
   logic                 act_taken, act_jump;
   logic [WORD_SIZE-1:0] act_target;
   logic [CTR_W-1:0]     ctr_inc, ctr_dec;

   assign if_idx = pc_IF[IDX_W-1:0];
   assign if_tag = pc_IF[WORD_SIZE-1:IDX_W];
   assign id_idx = pc_ID[IDX_W-1:0];
   assign id_tag = pc_ID[WORD_SIZE-1:IDX_W];
   assign if_hit = btb[if_idx].valid && (btb[if_idx].tag == if_tag);
   assign id_hit = btb[id_idx].valid && (btb[id_idx].tag == id_tag);

   // IF prediction: follow the BTB on a hit that is a jump or predicted taken
   always_comb begin
      pred_pc = pc_IF + WORD_SIZE'(1);
      if ((PRED_MODE != 0) && !reset && if_hit &&
          (btb[if_idx].jump || btb[if_idx].ctr[CTR_W-1]))
         pred_pc = btb[if_idx].target;
   end

   // ID resolution: first mismatch between actual and fetched next PC wins
   always_comb begin
      flush_code  = NICE_PRED;
      redirect_pc = pc_1_ID;
      if (valid_ID && !reset) begin
         if (is_jtype && (jmp_target != pc_after_ID)) begin
            flush_code  = JMP_FLUSH;
            redirect_pc = jmp_target;
         end else if (is_branch && branch_cond && (br_target != pc_after_ID)) begin
            flush_code  = BR_FLUSH;
            redirect_pc = br_target;
         end else if (is_branch && !branch_cond && (pc_1_ID != pc_after_ID)) begin
            flush_code  = NBR_FLUSH;
            redirect_pc = pc_1_ID;
         end else if (is_jr && (jr_target != pc_after_ID)) begin
            flush_code  = JR_FLUSH;
            redirect_pc = jr_target;
         end
      end
   end

   // Actual outcome of the ID instruction; JPR/JRL train like unconditional jumps
   always_comb begin
      train_en   = valid_ID && !stall_ID && (is_jtype || is_branch || is_jr);
      act_taken  = 1'b1;
      act_jump   = 1'b1;
      act_target = jr_target;
      if (is_jtype) begin
         act_target = jmp_target;
      end else if (is_branch) begin
         act_taken  = branch_cond;
         act_jump   = 1'b0;
         act_target = br_target;
      end
      ctr_inc = (btb[id_idx].ctr == CTR_MAX) ? CTR_MAX : btb[id_idx].ctr + CTR_W'(1);
      ctr_dec = (btb[id_idx].ctr == '0) ? '0 : btb[id_idx].ctr - CTR_W'(1);
   end

   // BTB training
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            btb[IDX_W'(i)].valid  <= 1'b0;
            btb[IDX_W'(i)].jump   <= 1'b0;
            btb[IDX_W'(i)].tag    <= '0;
            btb[IDX_W'(i)].target <= '0;
            btb[IDX_W'(i)].ctr    <= CTR_INIT;
         end
      end else if ((PRED_MODE != 0) && train_en) begin
         if (act_taken) begin
            if (id_hit) begin
               btb[id_idx].target <= act_target;
               btb[id_idx].ctr    <= btb[id_idx].jump ? CTR_MAX : ctr_inc;
            end else begin
               btb[id_idx].valid  <= 1'b1;
               btb[id_idx].jump   <= act_jump;
               btb[id_idx].tag    <= id_tag;
               btb[id_idx].target <= act_target;
               btb[id_idx].ctr    <= act_jump ? CTR_MAX : CTR_WEAK_T;
            end
         end else if (id_hit) begin
            btb[id_idx].ctr <= ctr_dec;
         end
      end
   end

   // Saturating perf counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (train_en) begin
         if (branch_cnt != CNT_MAX)
            branch_cnt <= branch_cnt + CNT_W'(1);
         if ((flush_code != NICE_PRED) && (mispred_cnt != CNT_MAX))
            mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_pred_unit.sv
module tb_branch_pred_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc_IF, pc_ID, pc_1_ID, pc_after_ID;
   logic        valid_ID, stall_ID, is_jtype, is_branch, is_jr, branch_cond;
   logic [15:0] jmp_target, br_target, jr_target;

   logic [15:0] m_pred, m_redir, m_bcnt, m_mcnt;
   logic [2:0]  m_code;
   logic [15:0] c_pred, c_redir;
   logic [2:0]  c_code;
   logic [3:0]  c_bcnt, c_mcnt;
   logic [15:0] s_pred, s_redir, s_bcnt, s_mcnt;
   logic [2:0]  s_code;

   int passes = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_pred_unit u_main (
      .clk(clk), .reset(reset), .pc_IF(pc_IF), .pred_pc(m_pred),
      .valid_ID(valid_ID), .stall_ID(stall_ID), .pc_ID(pc_ID), .pc_1_ID(pc_1_ID),
      .pc_after_ID(pc_after_ID), .is_jtype(is_jtype), .is_branch(is_branch),
      .is_jr(is_jr), .branch_cond(branch_cond), .jmp_target(jmp_target),
      .br_target(br_target), .jr_target(jr_target), .flush_code(m_code),
      .redirect_pc(m_redir), .branch_cnt(m_bcnt), .mispred_cnt(m_mcnt));

   branch_pred_unit #(.CNT_W(4)) u_cnt4 (
      .clk(clk), .reset(reset), .pc_IF(pc_IF), .pred_pc(c_pred),
      .valid_ID(valid_ID), .stall_ID(stall_ID), .pc_ID(pc_ID), .pc_1_ID(pc_1_ID),
      .pc_after_ID(pc_after_ID), .is_jtype(is_jtype), .is_branch(is_branch),
      .is_jr(is_jr), .branch_cond(branch_cond), .jmp_target(jmp_target),
      .br_target(br_target), .jr_target(jr_target), .flush_code(c_code),
      .redirect_pc(c_redir), .branch_cnt(c_bcnt), .mispred_cnt(c_mcnt));

   branch_pred_unit #(.PRED_MODE(0)) u_static (
      .clk(clk), .reset(reset), .pc_IF(pc_IF), .pred_pc(s_pred),
      .valid_ID(valid_ID), .stall_ID(stall_ID), .pc_ID(pc_ID), .pc_1_ID(pc_1_ID),
      .pc_after_ID(pc_after_ID), .is_jtype(is_jtype), .is_branch(is_branch),
      .is_jr(is_jr), .branch_cond(branch_cond), .jmp_target(jmp_target),
      .br_target(br_target), .jr_target(jr_target), .flush_code(s_code),
      .redirect_pc(s_redir), .branch_cnt(s_bcnt), .mispred_cnt(s_mcnt));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic clear_id();
      valid_ID = 0; stall_ID = 0; is_jtype = 0; is_branch = 0; is_jr = 0;
      branch_cond = 0; pc_ID = 0; pc_1_ID = 0; pc_after_ID = 0;
      jmp_target = 0; br_target = 0; jr_target = 0;
   endtask

   task automatic set_id(input logic [15:0] pc, input logic [15:0] after);
      valid_ID = 1; pc_ID = pc; pc_1_ID = pc + 16'd1; pc_after_ID = after;
   endtask

   // Pass one rising edge, return at the following falling edge
   task automatic cycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset = 1; pc_IF = 16'h0010;
      clear_id();
      // Resolution is suppressed while reset is held
      set_id(16'h0020, 16'h0021); is_jtype = 1; jmp_target = 16'h0100;
      #2;
      check("rst_code", 32'(m_code), 0);
      check("rst_redir", 32'(m_redir), 32'h0021);
      check("rst_pred", 32'(m_pred), 32'h0011);
      cycle(); cycle();
      reset = 0; clear_id(); #1;

      check("post_pred", 32'(m_pred), 32'h0011);
      check("post_code", 32'(m_code), 0);
      check("post_bcnt", 32'(m_bcnt), 0);
      check("post_mcnt", 32'(m_mcnt), 0);

      // JMP miss at 0x20 -> 0x100; prediction in the same cycle is pre-edge
      set_id(16'h0020, 16'h0021); is_jtype = 1; jmp_target = 16'h0100; pc_IF = 16'h0020; #1;
      check("jmp_code", 32'(m_code), 1);
      check("jmp_redir", 32'(m_redir), 32'h0100);
      check("jmp_nobypass", 32'(m_pred), 32'h0021);
      cycle(); clear_id(); #1;
      check("jmp_pred", 32'(m_pred), 32'h0100);
      check("jmp_static_pred", 32'(s_pred), 32'h0021);
      check("jmp_bcnt", 32'(m_bcnt), 1);
      check("jmp_mcnt", 32'(m_mcnt), 1);
      pc_IF = 16'h0030; #1;
      check("alias_miss", 32'(m_pred), 32'h0031);

      // Branch at 0x30 -> 0x40: taken (miss), taken (hit), not taken, not taken
      set_id(16'h0030, 16'h0031); is_branch = 1; branch_cond = 1; br_target = 16'h0040; #1;
      check("br1_code", 32'(m_code), 2);
      check("br1_redir", 32'(m_redir), 32'h0040);
      check("br1_static_code", 32'(s_code), 2);
      cycle();
      check("br1_pred", 32'(m_pred), 32'h0040);
      pc_IF = 16'h0020; #1;
      check("jmp_evicted", 32'(m_pred), 32'h0021);
      pc_IF = 16'h0030;
      pc_after_ID = 16'h0040; #1;
      check("br2_code", 32'(m_code), 0);
      check("br2_redir", 32'(m_redir), 32'h0031);
      cycle();
      branch_cond = 0; #1;
      check("br3_code", 32'(m_code), 3);
      check("br3_redir", 32'(m_redir), 32'h0031);
      cycle();
      check("br3_pred", 32'(m_pred), 32'h0040);
      pc_after_ID = 16'h0031; #1;
      check("br4_code", 32'(m_code), 0);
      cycle(); clear_id(); #1;
      check("br4_pred", 32'(m_pred), 32'h0031);
      check("br4_bcnt", 32'(m_bcnt), 5);
      check("br4_mcnt", 32'(m_mcnt), 3);

      // JPR while stalled: flush reported, nothing trained or counted
      set_id(16'h0050, 16'h0051); is_jr = 1; jr_target = 16'h1234; stall_ID = 1;
      pc_IF = 16'h0050; #1;
      check("jr_stall_code", 32'(m_code), 4);
      check("jr_stall_redir", 32'(m_redir), 32'h1234);
      cycle();
      check("jr_stall_pred", 32'(m_pred), 32'h0051);
      check("jr_stall_bcnt", 32'(m_bcnt), 5);
      check("jr_stall_mcnt", 32'(m_mcnt), 3);
      stall_ID = 0; #1;
      cycle(); clear_id(); #1;
      check("jr_pred", 32'(m_pred), 32'h1234);
      check("jr_bcnt", 32'(m_bcnt), 6);
      check("jr_mcnt", 32'(m_mcnt), 4);

      pc_IF = 16'hFFFF; #1;
      check("wrap_pred", 32'(m_pred), 32'h0000);
      check("wrap_static", 32'(s_pred), 32'h0000);

      // 20 mispredicted jumps saturate the 4-bit counters
      set_id(16'h0060, 16'h0061); is_jtype = 1; jmp_target = 16'h0200;
      for (int i = 0; i < 20; i++) cycle();
      clear_id(); pc_IF = 16'h0060; #1;
      check("sat_c_mcnt", 32'(c_mcnt), 32'hF);
      check("sat_c_bcnt", 32'(c_bcnt), 32'hF);
      check("sat_m_bcnt", 32'(m_bcnt), 26);
      check("sat_m_mcnt", 32'(m_mcnt), 24);
      check("sat_s_mcnt", 32'(s_mcnt), 24);
      check("sat_pred", 32'(m_pred), 32'h0200);
      check("sat_static_pred", 32'(s_pred), 32'h0061);

      // Static build never learns: taken branch flushes every time
      set_id(16'h0030, 16'h0031); is_branch = 1; branch_cond = 1; br_target = 16'h0040;
      pc_IF = 16'h0030; #1;
      check("st1_code", 32'(s_code), 2);
      cycle();
      check("st2_code", 32'(s_code), 2);
      check("st2_redir", 32'(s_redir), 32'h0040);
      check("st2_pred", 32'(s_pred), 32'h0031);
      check("st2_main_pred", 32'(m_pred), 32'h0040);
      cycle(); clear_id(); #1;

      // Reset mid-cycle with a training request pending
      set_id(16'h0070, 16'h0071); is_jtype = 1; jmp_target = 16'h0300; pc_IF = 16'h0070;
      #1 reset = 1; #1;
      check("mid_rst_bcnt", 32'(m_bcnt), 0);
      check("mid_rst_mcnt", 32'(m_mcnt), 0);
      check("mid_rst_code", 32'(m_code), 0);
      cycle();
      reset = 0; clear_id(); #1;
      check("mid_rst_pred70", 32'(m_pred), 32'h0071);
      pc_IF = 16'h0030; #1;
      check("mid_rst_pred30", 32'(m_pred), 32'h0031);
      check("mid_rst_bcnt2", 32'(m_bcnt), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
